// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register,
// plus saturating stall/redirect event counters for debug readout.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      irom_addr,
    input  logic [31:0]      irom_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_pc4_q, id_pc4_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d           = pc_q;
        id_pc_d        = id_pc_q;
        id_pc4_d       = id_pc4_q;
        id_inst_d      = id_inst_q;
        id_valid_d     = id_valid_q;
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;

        // Redirect outranks stall for the PC; IF/ID only moves when not stalled.
        if (redirect) begin
            pc_d = redirect_pc & ~32'h0000_0003;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        if (!stall) begin
            id_pc_d  = pc_q;
            id_pc4_d = pc_plus4;
            if (redirect) begin
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end else begin
                id_inst_d  = irom_inst;
                id_valid_d = 1'b1;
            end
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (redirect && (redirect_cnt_q != '1)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            id_pc_q        <= RESET_PC;
            id_pc4_q       <= RESET_PC + 32'd4;
            id_inst_q      <= NOP_INST;
            id_valid_q     <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            pc_q           <= pc_d;
            id_pc_q        <= id_pc_d;
            id_pc4_q       <= id_pc4_d;
            id_inst_q      <= id_inst_d;
            id_valid_q     <= id_valid_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign irom_addr    = pc_q;
    assign id_pc        = id_pc_q;
    assign id_pc4       = id_pc4_q;
    assign id_inst      = id_inst_q;
    assign id_valid     = id_valid_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboarded directed test of if_stage_fetch: a default instance plus a
// wrap/saturation instance (RESET_PC near the top of memory, 4-bit counters).
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        xinj = 1'b0;

    logic [31:0] addr1, inst1, id_pc1, id_pc41, id_inst1;
    logic        id_valid1;
    logic [15:0] scnt1, rcnt1;

    logic [31:0] addr2, inst2, id_pc2, id_pc42, id_inst2;
    logic        id_valid2;
    logic [3:0]  scnt2, rcnt2;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h1234_5000;
    endfunction

    // Bench-side instruction ROM; optionally drives X to prove it never leaks into IF/ID.
    assign inst1 = xinj ? 32'hxxxx_xxxx : rom(addr1);
    assign inst2 = xinj ? 32'hxxxx_xxxx : rom(addr2);

    if_stage_fetch dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .irom_addr(addr1), .irom_inst(inst1), .id_pc(id_pc1), .id_pc4(id_pc41),
        .id_inst(id_inst1), .id_valid(id_valid1), .stall_cnt(scnt1), .redirect_cnt(rcnt1)
    );

    if_stage_fetch #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(32'h0000_0013), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .irom_addr(addr2), .irom_inst(inst2), .id_pc(id_pc2), .id_pc4(id_pc42),
        .id_inst(id_inst2), .id_valid(id_valid2), .stall_cnt(scnt2), .redirect_cnt(rcnt2)
    );

    typedef struct {
        int unsigned sel;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] scnt;
        logic [31:0] rcnt;
    } exp_t;

    exp_t q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned step_no = 0;

    function automatic void chk(input string name, input int unsigned s,
                                input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d step %0d): got %h expected %h", name, s, step_no, act, exp);
        end
    endfunction

    // Monitor: each falling edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 1) begin
                    chk("irom_addr", 1, addr1, e.addr);
                    chk("id_pc", 1, id_pc1, e.pc);
                    chk("id_pc4", 1, id_pc41, e.pc + 32'd4);
                    chk("id_inst", 1, id_inst1, e.inst);
                    chk("id_valid", 1, {31'd0, id_valid1}, {31'd0, e.valid});
                    chk("stall_cnt", 1, {16'd0, scnt1}, e.scnt);
                    chk("redirect_cnt", 1, {16'd0, rcnt1}, e.rcnt);
                end else begin
                    chk("irom_addr", 2, addr2, e.addr);
                    chk("id_pc", 2, id_pc2, e.pc);
                    chk("id_pc4", 2, id_pc42, e.pc + 32'd4);
                    chk("id_inst", 2, id_inst2, e.inst);
                    chk("id_valid", 2, {31'd0, id_valid2}, {31'd0, e.valid});
                    chk("stall_cnt", 2, {28'd0, scnt2}, e.scnt);
                    chk("redirect_cnt", 2, {28'd0, rcnt2}, e.rcnt);
                end
                step_no++;
            end
        end
    end

    // Drive inputs for one cycle and queue the state expected before the next rising edge.
    task automatic step(input int unsigned sel, input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] ea, input logic [31:0] ep,
                        input logic [31:0] ei, input logic ev, input logic [31:0] es,
                        input logic [31:0] er);
        exp_t e;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        e.sel = sel; e.addr = ea; e.pc = ep; e.inst = ei; e.valid = ev; e.scnt = es; e.rcnt = er;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        exp_t e;
        @(posedge clk);
        #1;
        // Reset held, then plain sequential fetch
        step(1, 1, 0, 0, 0, 32'h00, 32'h00, NOP,          0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h00, 32'h00, NOP,          0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h04, 32'h00, rom(32'h00), 1, 0, 0);
        step(1, 0, 0, 0, 0, 32'h08, 32'h04, rom(32'h04), 1, 0, 0);
        step(1, 0, 0, 0, 0, 32'h0C, 32'h08, rom(32'h08), 1, 0, 0);
        // Three-cycle stall at pc=0x10 with X on the ROM bus
        xinj = 1'b1;
        step(1, 0, 1, 0, 0, 32'h10, 32'h0C, rom(32'h0C), 1, 0, 0);
        step(1, 0, 1, 0, 0, 32'h10, 32'h0C, rom(32'h0C), 1, 1, 0);
        step(1, 0, 1, 0, 0, 32'h10, 32'h0C, rom(32'h0C), 1, 2, 0);
        xinj = 1'b0;
        step(1, 0, 0, 0, 0, 32'h10, 32'h0C, rom(32'h0C), 1, 3, 0);
        step(1, 0, 0, 0, 0, 32'h14, 32'h10, rom(32'h10), 1, 3, 0);
        // Stall with redirect in the third cycle
        step(1, 0, 1, 0, 0,        32'h18, 32'h14, rom(32'h14), 1, 3, 0);
        step(1, 0, 1, 0, 0,        32'h18, 32'h14, rom(32'h14), 1, 4, 0);
        step(1, 0, 1, 1, 32'h40,   32'h18, 32'h14, rom(32'h14), 1, 5, 0);
        step(1, 0, 0, 0, 0,        32'h40, 32'h14, rom(32'h14), 1, 6, 1);
        step(1, 0, 0, 0, 0,        32'h44, 32'h40, rom(32'h40), 1, 6, 1);
        // Unaligned redirect flushes IF/ID
        step(1, 0, 0, 1, 32'h83,   32'h48, 32'h44, rom(32'h44), 1, 6, 1);
        step(1, 0, 0, 0, 0,        32'h80, 32'h48, NOP,          0, 6, 2);
        step(1, 0, 0, 0, 0,        32'h84, 32'h80, rom(32'h80), 1, 6, 2);
        step(1, 0, 1, 0, 0,        32'h88, 32'h84, rom(32'h84), 1, 6, 2);
        // Asynchronous reset between edges, mid-stall
        stall = 1'b1;
        #2;
        rst = 1'b1;
        e.sel = 1; e.addr = 32'h00; e.pc = 32'h00; e.inst = NOP; e.valid = 0; e.scnt = 0; e.rcnt = 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        step(1, 1, 0, 0, 0, 32'h00, 32'h00, NOP,          0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h00, 32'h00, NOP,          0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h04, 32'h00, rom(32'h00), 1, 0, 0);

        // Second instance: PC wrap and 4-bit counter saturation
        step(2, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, NOP,                0, 0, 0);
        step(2, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, NOP,                0, 0, 0);
        step(2, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, rom(32'hFFFF_FFF8), 1, 0, 0);
        step(2, 0, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1, 0, 0);
        for (int k = 0; k < 21; k++) begin
            step(2, 0, 1, 0, 0, 32'h04, 32'h00, rom(32'h00), 1, (k < 15) ? k : 15, 0);
        end
        step(2, 0, 0, 0, 0, 32'h04, 32'h00, rom(32'h00), 1, 15, 0);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
